// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer slice.
//   rob_entry_t : one ROB slot (valid, done, destination register, result value)
//   RD_W / XLEN : destination register index width and result width
package rob_pkg;

  localparam int RD_W = 5;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic [RD_W-1:0] rd_s;
    logic [XLEN-1:0] rd_v;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of every per-lane bus of the reorder buffer.
//   master : core side (dispatch, functional-unit writeback, issue lookup)
//   slave  : the reorder buffer itself
// Lane arrays are packed [SUPERSCALAR-1:0]; lane 0 is the oldest / first lane.
interface reorder_buffer_if #(
  parameter int SUPERSCALAR = 1,
  parameter int ROB_DEPTH   = 4
);
  import rob_pkg::*;

  logic [SUPERSCALAR-1:0]                alloc_req;
  logic [SUPERSCALAR-1:0][RD_W-1:0]      alloc_rd_s;
  logic                                  alloc_ready;
  logic [SUPERSCALAR-1:0][ROB_DEPTH-1:0] alloc_rob;

  logic [SUPERSCALAR-1:0]                wb_valid;
  logic [SUPERSCALAR-1:0][ROB_DEPTH-1:0] wb_rob;
  logic [SUPERSCALAR-1:0][XLEN-1:0]      wb_rd_v;

  logic [SUPERSCALAR-1:0]                commit_regf_we;
  logic [SUPERSCALAR-1:0][RD_W-1:0]      commit_rd_s;
  logic [SUPERSCALAR-1:0][XLEN-1:0]      commit_rd_v;
  logic [SUPERSCALAR-1:0][ROB_DEPTH-1:0] commit_rob;

  logic [SUPERSCALAR-1:0][ROB_DEPTH-1:0] lkp_rs1_rob;
  logic [SUPERSCALAR-1:0]                lkp_rs1_ready;
  logic [SUPERSCALAR-1:0][XLEN-1:0]      lkp_rs1_v;
  logic [SUPERSCALAR-1:0][ROB_DEPTH-1:0] lkp_rs2_rob;
  logic [SUPERSCALAR-1:0]                lkp_rs2_ready;
  logic [SUPERSCALAR-1:0][XLEN-1:0]      lkp_rs2_v;

  logic                                  rob_empty;
  logic                                  rob_full;

  modport master (
    output alloc_req, alloc_rd_s, wb_valid, wb_rob, wb_rd_v, lkp_rs1_rob, lkp_rs2_rob,
    input  alloc_ready, alloc_rob, commit_regf_we, commit_rd_s, commit_rd_v, commit_rob,
           lkp_rs1_ready, lkp_rs1_v, lkp_rs2_ready, lkp_rs2_v, rob_empty, rob_full
  );

  modport slave (
    input  alloc_req, alloc_rd_s, wb_valid, wb_rob, wb_rd_v, lkp_rs1_rob, lkp_rs2_rob,
    output alloc_ready, alloc_rob, commit_regf_we, commit_rd_s, commit_rd_v, commit_rob,
           lkp_rs1_ready, lkp_rs1_v, lkp_rs2_ready, lkp_rs2_v, rob_empty, rob_full
  );

endinterface

// File: rtl/reorder_buffer_commit_select.sv
// rob_commit_select: picks which head entries retire this cycle.
//   head_done_i  : per lane, entry head+i is valid and done
//   retire_en_o  : per lane retire enable (prefix AND, so retirement stays in order)
//   retire_cnt_o : number of retiring lanes
module rob_commit_select #(
  parameter int SUPERSCALAR = 1,
  parameter int CW          = $clog2(SUPERSCALAR + 1)
) (
  input  logic [SUPERSCALAR-1:0] head_done_i,
  output logic [SUPERSCALAR-1:0] retire_en_o,
  output logic [CW-1:0]          retire_cnt_o
);

  logic run;

  always_comb begin
    retire_en_o  = '0;
    retire_cnt_o = '0;
    run          = 1'b1;
    for (int i = 0; i < SUPERSCALAR; i++) begin
      run            = run & head_done_i[i];
      retire_en_o[i] = run;
      retire_cnt_o   = retire_cnt_o + CW'(run);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with tag-indexed writeback and operand lookup.
//   clk, rst : clock, synchronous active-high reset (discards every entry)
//   bus      : reorder_buffer_if.slave -- alloc, writeback, commit, lookup, empty/full
// Head/tail pointers carry one extra wrap bit so a full queue differs from an empty one.
// Build option ROB_WB_BYPASS_EN: lookups also see same-cycle writebacks (highest lane wins).
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int SUPERSCALAR = 1,
  parameter int ROB_DEPTH   = 4
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);

  localparam int N  = 2 ** ROB_DEPTH;
  localparam int PW = ROB_DEPTH + 1;
  localparam int CW = $clog2(SUPERSCALAR + 1);
  localparam logic [PW-1:0] FULL_CNT  = {1'b1, {ROB_DEPTH{1'b0}}};
  localparam logic [PW-1:0] READY_MAX = PW'(N - SUPERSCALAR);

  typedef logic [ROB_DEPTH-1:0] tag_t;

  rob_entry_t             ent_q [N];
  rob_entry_t             ent_d [N];
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d, count;
  logic                   alloc_ready;
  logic [CW-1:0]          alloc_cnt, retire_cnt;
  logic [SUPERSCALAR-1:0] head_done, retire_en;
  tag_t                   head_tag [SUPERSCALAR];
  tag_t                   tail_tag [SUPERSCALAR];

  // Readiness looks only at registered occupancy; slots freed by this cycle's commit wait a cycle.
  assign count       = tail_q - head_q;
  assign alloc_ready = (count <= READY_MAX);

  assign bus.alloc_ready = alloc_ready;
  assign bus.rob_empty   = (count == '0);
  assign bus.rob_full    = (count == FULL_CNT);

  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < SUPERSCALAR; i++) begin
      head_tag[i]      = head_q[ROB_DEPTH-1:0] + tag_t'(i);
      tail_tag[i]      = tail_q[ROB_DEPTH-1:0] + tag_t'(i);
      head_done[i]     = ent_q[head_tag[i]].valid & ent_q[head_tag[i]].done;
      bus.alloc_rob[i] = tail_tag[i];
      alloc_cnt        = alloc_cnt + CW'(bus.alloc_req[i]);
    end
  end

  rob_commit_select #(
    .SUPERSCALAR (SUPERSCALAR),
    .CW          (CW)
  ) u_commit_select (
    .head_done_i  (head_done),
    .retire_en_o  (retire_en),
    .retire_cnt_o (retire_cnt)
  );

  always_comb begin
    for (int i = 0; i < SUPERSCALAR; i++) begin
      bus.commit_regf_we[i] = retire_en[i];
      bus.commit_rob[i]     = head_tag[i];
      bus.commit_rd_s[i]    = retire_en[i] ? ent_q[head_tag[i]].rd_s : '0;
      bus.commit_rd_v[i]    = retire_en[i] ? ent_q[head_tag[i]].rd_v : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < SUPERSCALAR; i++) begin
      bus.lkp_rs1_ready[i] = ent_q[bus.lkp_rs1_rob[i]].valid & ent_q[bus.lkp_rs1_rob[i]].done;
      bus.lkp_rs1_v[i]     = ent_q[bus.lkp_rs1_rob[i]].rd_v;
      bus.lkp_rs2_ready[i] = ent_q[bus.lkp_rs2_rob[i]].valid & ent_q[bus.lkp_rs2_rob[i]].done;
      bus.lkp_rs2_v[i]     = ent_q[bus.lkp_rs2_rob[i]].rd_v;
`ifdef ROB_WB_BYPASS_EN
      // Ascending lane order lets the highest matching writeback lane win.
      for (int j = 0; j < SUPERSCALAR; j++) begin
        if (bus.wb_valid[j] && ent_q[bus.wb_rob[j]].valid) begin
          if (bus.wb_rob[j] == bus.lkp_rs1_rob[i]) begin
            bus.lkp_rs1_ready[i] = 1'b1;
            bus.lkp_rs1_v[i]     = bus.wb_rd_v[j];
          end
          if (bus.wb_rob[j] == bus.lkp_rs2_rob[i]) begin
            bus.lkp_rs2_ready[i] = 1'b1;
            bus.lkp_rs2_v[i]     = bus.wb_rd_v[j];
          end
        end
      end
`endif
    end
  end

  // Retire, writeback and alloc always touch disjoint entries, so their order here is free.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < SUPERSCALAR; i++) begin
      if (retire_en[i]) begin
        ent_d[head_tag[i]].valid = 1'b0;
        ent_d[head_tag[i]].done  = 1'b0;
      end
    end
    for (int i = 0; i < SUPERSCALAR; i++) begin
      if (bus.wb_valid[i] && ent_q[bus.wb_rob[i]].valid) begin
        ent_d[bus.wb_rob[i]].done = 1'b1;
        ent_d[bus.wb_rob[i]].rd_v = bus.wb_rd_v[i];
      end
    end
    if (alloc_ready) begin
      for (int i = 0; i < SUPERSCALAR; i++) begin
        if (bus.alloc_req[i]) begin
          ent_d[tail_tag[i]].valid = 1'b1;
          ent_d[tail_tag[i]].done  = 1'b0;
          ent_d[tail_tag[i]].rd_s  = bus.alloc_rd_s[i];
          ent_d[tail_tag[i]].rd_v  = '0;
        end
      end
    end
    head_d = head_q + PW'(retire_cnt);
    tail_d = tail_q + PW'(alloc_ready ? alloc_cnt : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int k = 0; k < N; k++) ent_q[k] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ent_q  <= ent_d;
    end
  end

  logic wb_to_invalid, wb_dup, alloc_packed;

  always_comb begin
    wb_to_invalid = 1'b0;
    wb_dup        = 1'b0;
    for (int i = 0; i < SUPERSCALAR; i++) begin
      if (bus.wb_valid[i] && !ent_q[bus.wb_rob[i]].valid) wb_to_invalid = 1'b1;
      for (int j = i + 1; j < SUPERSCALAR; j++) begin
        if (bus.wb_valid[i] && bus.wb_valid[j] && bus.wb_rob[i] == bus.wb_rob[j]) wb_dup = 1'b1;
      end
    end
    // A packed request vector is a run of ones from lane 0: req & (req + 1) == 0.
    alloc_packed = ((bus.alloc_req & (bus.alloc_req + SUPERSCALAR'(1))) == '0);
  end

  a_alloc_packed:  assert property (@(posedge clk) disable iff (rst) alloc_packed);
  a_wb_valid_tag:  assert property (@(posedge clk) disable iff (rst) !wb_to_invalid);
  a_wb_unique_tag: assert property (@(posedge clk) disable iff (rst) !wb_dup);

endmodule
